sound_fx_sequencer: RTL and testbench

Controller that drives the parameter inputs of the SN76477 complex sound generator from a small table of programmable sound-effect descriptors. Four requesters (game events) trigger effects. A fixed-priority arbiter picks one, and a tick-based sequencer plays it for a programmed duration while sweeping VCO1 frequency. It sits between the game/CPU logic and the sound generator.

---
 rtl/sound_fx_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_sound_fx_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_fx_sequencer.sv
// Effect sequencer for the SN76477: four programmable descriptors, fixed-priority
// trigger arbitration, and a tick-based player that sweeps VCO1 while an effect runs.
module sound_fx_sequencer #(
    parameter int TICK_DIV = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  trig,
    input  logic        cfg_we,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic [11:0] vco1_freq,
    output logic [11:0] vco2_freq,
    output logic [11:0] noise_freq,
    output logic [9:0]  lfo_freq,
    output logic        vco1_select,
    output logic        vco2_select,
    output logic        noise_select,
    output logic [2:0]  lfo_shift,
    output logic [3:0]  mixer,
    output logic        busy,
    output logic [1:0]  active_slot,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    // ctl packs {noise_sel, vco2_sel, vco1_sel, lfo_shift[2:0], mixer[3:0]}.
    logic [11:0] v1_tbl_q [4], v1_tbl_d [4];
    logic [11:0] v2_tbl_q [4], v2_tbl_d [4];
    logic [11:0] nz_tbl_q [4], nz_tbl_d [4];
    logic [9:0]  lfo_tbl_q [4], lfo_tbl_d [4];
    logic [9:0]  ctl_tbl_q [4], ctl_tbl_d [4];
    logic [7:0]  sw_tbl_q [4], sw_tbl_d [4];
    logic [15:0] dur_tbl_q [4], dur_tbl_d [4];

    state_t      state_q, state_d;
    logic [3:0]  pend_q, pend_d;
    logic [15:0] tick_q, tick_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  sweep_q, sweep_d;
    logic [11:0] vco1_q, vco1_d;
    logic [11:0] vco2_q, vco2_d;
    logic [11:0] noise_q, noise_d;
    logic [9:0]  lfo_q, lfo_d;
    logic [9:0]  ctl_q, ctl_d;
    logic [1:0]  slot_q, slot_d;
    logic        done_q, done_d;

    logic [3:0]  eff_pend;
    logic [1:0]  sel;
    logic        preempt;
    logic [13:0] sweep_sum;
    logic [11:0] swept;

    always_comb begin
        v1_tbl_d  = v1_tbl_q;
        v2_tbl_d  = v2_tbl_q;
        nz_tbl_d  = nz_tbl_q;
        lfo_tbl_d = lfo_tbl_q;
        ctl_tbl_d = ctl_tbl_q;
        sw_tbl_d  = sw_tbl_q;
        dur_tbl_d = dur_tbl_q;
        if (cfg_we) begin
            case (cfg_addr[2:0])
                3'd0: v1_tbl_d[cfg_addr[4:3]]  = cfg_data[11:0];
                3'd1: v2_tbl_d[cfg_addr[4:3]]  = cfg_data[11:0];
                3'd2: nz_tbl_d[cfg_addr[4:3]]  = cfg_data[11:0];
                3'd3: lfo_tbl_d[cfg_addr[4:3]] = cfg_data[9:0];
                3'd4: ctl_tbl_d[cfg_addr[4:3]] = {cfg_data[14:12], cfg_data[10:8], cfg_data[3:0]};
                3'd5: sw_tbl_d[cfg_addr[4:3]]  = cfg_data[7:0];
                3'd6: dur_tbl_d[cfg_addr[4:3]] = cfg_data;
                default: ;
            endcase
        end
    end

    // A trigger arriving this cycle counts as pending for arbitration decisions.
    assign eff_pend  = pend_q | trig;
    assign sweep_sum = {2'b00, vco1_q} + {{6{sweep_q[7]}}, sweep_q};
    assign swept     = sweep_sum[13] ? 12'd0 : (sweep_sum[12] ? 12'hFFF : sweep_sum[11:0]);

    always_comb begin
        sel     = 2'd0;
        preempt = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) sel = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (eff_pend[i] && (i < int'(slot_q))) preempt = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = eff_pend;
        tick_d  = tick_q;
        rem_d   = rem_q;
        sweep_d = sweep_q;
        vco1_d  = vco1_q;
        vco2_d  = vco2_q;
        noise_d = noise_q;
        lfo_d   = lfo_q;
        ctl_d   = ctl_q;
        slot_d  = slot_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (eff_pend != 4'd0) state_d = S_LOAD;
            end
            S_LOAD: begin
                pend_d  = (pend_q & ~(4'b0001 << sel)) | trig;
                vco1_d  = v1_tbl_q[sel];
                vco2_d  = v2_tbl_q[sel];
                noise_d = nz_tbl_q[sel];
                lfo_d   = lfo_tbl_q[sel];
                ctl_d   = ctl_tbl_q[sel];
                sweep_d = sw_tbl_q[sel];
                rem_d   = dur_tbl_q[sel];
                slot_d  = sel;
                tick_d  = 16'd0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (preempt) begin
                    state_d = S_LOAD;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = 16'd0;
                    if (rem_q <= 16'd1) begin
                        done_d  = 1'b1;
                        state_d = (eff_pend != 4'd0) ? S_LOAD : S_IDLE;
                    end else begin
                        rem_d  = rem_q - 16'd1;
                        vco1_d = swept;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) ctl_d[3:0] = 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                v1_tbl_q[i]  <= '0;
                v2_tbl_q[i]  <= '0;
                nz_tbl_q[i]  <= '0;
                lfo_tbl_q[i] <= '0;
                ctl_tbl_q[i] <= '0;
                sw_tbl_q[i]  <= '0;
                dur_tbl_q[i] <= '0;
            end
            state_q <= S_IDLE;
            pend_q  <= '0;
            tick_q  <= '0;
            rem_q   <= '0;
            sweep_q <= '0;
            vco1_q  <= '0;
            vco2_q  <= '0;
            noise_q <= '0;
            lfo_q   <= '0;
            ctl_q   <= '0;
            slot_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            v1_tbl_q  <= v1_tbl_d;
            v2_tbl_q  <= v2_tbl_d;
            nz_tbl_q  <= nz_tbl_d;
            lfo_tbl_q <= lfo_tbl_d;
            ctl_tbl_q <= ctl_tbl_d;
            sw_tbl_q  <= sw_tbl_d;
            dur_tbl_q <= dur_tbl_d;
            state_q   <= state_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            rem_q     <= rem_d;
            sweep_q   <= sweep_d;
            vco1_q    <= vco1_d;
            vco2_q    <= vco2_d;
            noise_q   <= noise_d;
            lfo_q     <= lfo_d;
            ctl_q     <= ctl_d;
            slot_q    <= slot_d;
            done_q    <= done_d;
        end
    end

    assign vco1_freq    = vco1_q;
    assign vco2_freq    = vco2_q;
    assign noise_freq   = noise_q;
    assign lfo_freq     = lfo_q;
    assign noise_select = ctl_q[9];
    assign vco2_select  = ctl_q[8];
    assign vco1_select  = ctl_q[7];
    assign lfo_shift    = ctl_q[6:4];
    assign mixer        = ctl_q[3:0];
    assign busy         = (state_q != S_IDLE);
    assign active_slot  = slot_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sound_fx_sequencer.sv
// Directed bench for sound_fx_sequencer: an elapsed-cycle reference model of effect
// playback checked every cycle, plus hand-computed expectations at key cycles.
module tb_sound_fx_sequencer;
    localparam int TD = 4;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_PLAY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  trig = 4'd0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = 5'd0;
    logic [15:0] cfg_data = 16'd0;
    logic [11:0] vco1_freq, vco2_freq, noise_freq;
    logic [9:0]  lfo_freq;
    logic        vco1_select, vco2_select, noise_select;
    logic [2:0]  lfo_shift;
    logic [3:0]  mixer;
    logic        busy;
    logic [1:0]  active_slot;
    logic        done;

    int checks = 0;
    int errors = 0;

    sound_fx_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .trig(trig), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .vco1_freq(vco1_freq), .vco2_freq(vco2_freq),
        .noise_freq(noise_freq), .lfo_freq(lfo_freq), .vco1_select(vco1_select),
        .vco2_select(vco2_select), .noise_select(noise_select), .lfo_shift(lfo_shift),
        .mixer(mixer), .busy(busy), .active_slot(active_slot), .done(done)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int clamp12(input int v);
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Bench copy of the descriptor table plus the current effect's snapshot; vco1 is
    // derived in closed form from the number of whole ticks elapsed since the load.
    int         tb_v1 [4], tb_v2 [4], tb_nz [4], tb_lfo [4], tb_sw [4], tb_dur [4];
    logic [15:0] tb_ctl [4];
    int         m_phase, m_cyc, m_load_cyc, m_len, m_start, m_sweep, m_el, m_steps, m_pick;
    logic [3:0] m_pend, m_eff;
    logic       m_pre;
    int         e_v1, e_v2, e_nz, e_lfo, e_shift, e_mixer, e_slot, e_done;
    int         e_v1sel, e_v2sel, e_nzsel;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                tb_v1[i] = 0; tb_v2[i] = 0; tb_nz[i] = 0; tb_lfo[i] = 0;
                tb_sw[i] = 0; tb_dur[i] = 0; tb_ctl[i] = 16'd0;
            end
            m_phase = P_IDLE; m_pend = 4'd0; m_cyc = 0; m_load_cyc = 0;
            m_len = 1; m_start = 0; m_sweep = 0;
            e_v1 = 0; e_v2 = 0; e_nz = 0; e_lfo = 0; e_shift = 0; e_mixer = 0;
            e_slot = 0; e_done = 0; e_v1sel = 0; e_v2sel = 0; e_nzsel = 0;
        end else begin
            m_eff  = m_pend | trig;
            e_done = 0;
            if (m_phase == P_IDLE) begin
                m_pend = m_eff;
                if (m_eff != 4'd0) m_phase = P_LOAD;
            end else if (m_phase == P_LOAD) begin
                m_pick = 0;
                for (int i = 3; i >= 0; i--) if (m_pend[i]) m_pick = i;
                m_pend[m_pick] = 1'b0;
                m_pend     = m_pend | trig;
                m_load_cyc = m_cyc;
                m_start    = tb_v1[m_pick];
                m_sweep    = (tb_sw[m_pick] >= 128) ? tb_sw[m_pick] - 256 : tb_sw[m_pick];
                m_len      = (tb_dur[m_pick] == 0) ? 1 : tb_dur[m_pick];
                e_slot  = m_pick;
                e_v1    = tb_v1[m_pick];
                e_v2    = tb_v2[m_pick];
                e_nz    = tb_nz[m_pick];
                e_lfo   = tb_lfo[m_pick];
                e_mixer = int'(tb_ctl[m_pick][3:0]);
                e_shift = int'(tb_ctl[m_pick][10:8]);
                e_v1sel = int'(tb_ctl[m_pick][12]);
                e_v2sel = int'(tb_ctl[m_pick][13]);
                e_nzsel = int'(tb_ctl[m_pick][14]);
                m_phase = P_PLAY;
            end else begin
                m_pend = m_eff;
                m_el   = m_cyc - m_load_cyc;
                m_pre  = 1'b0;
                for (int i = 0; i < 4; i++) if (i < e_slot && m_eff[i]) m_pre = 1'b1;
                if (m_pre) begin
                    m_phase = P_LOAD;
                end else begin
                    m_steps = m_el / TD;
                    if (m_steps > m_len - 1) m_steps = m_len - 1;
                    e_v1 = clamp12(m_start + m_steps * m_sweep);
                    if ((m_el % TD == 0) && (m_el / TD >= m_len)) begin
                        e_done  = 1;
                        m_phase = (m_eff != 4'd0) ? P_LOAD : P_IDLE;
                    end
                end
            end
            if (m_phase == P_IDLE) e_mixer = 0;
            if (cfg_we) begin
                case (cfg_addr[2:0])
                    3'd0: tb_v1[cfg_addr[4:3]]  = int'(cfg_data[11:0]);
                    3'd1: tb_v2[cfg_addr[4:3]]  = int'(cfg_data[11:0]);
                    3'd2: tb_nz[cfg_addr[4:3]]  = int'(cfg_data[11:0]);
                    3'd3: tb_lfo[cfg_addr[4:3]] = int'(cfg_data[9:0]);
                    3'd4: tb_ctl[cfg_addr[4:3]] = cfg_data;
                    3'd5: tb_sw[cfg_addr[4:3]]  = int'(cfg_data[7:0]);
                    3'd6: tb_dur[cfg_addr[4:3]] = int'(cfg_data);
                    default: ;
                endcase
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("vco1_freq", int'(vco1_freq), e_v1);
            chk("vco2_freq", int'(vco2_freq), e_v2);
            chk("noise_freq", int'(noise_freq), e_nz);
            chk("lfo_freq", int'(lfo_freq), e_lfo);
            chk("vco1_select", int'(vco1_select), e_v1sel);
            chk("vco2_select", int'(vco2_select), e_v2sel);
            chk("noise_select", int'(noise_select), e_nzsel);
            chk("lfo_shift", int'(lfo_shift), e_shift);
            chk("mixer", int'(mixer), e_mixer);
            chk("busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
            chk("active_slot", int'(active_slot), e_slot);
            chk("done", int'(done), e_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] slot, input logic [2:0] field, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_addr = {slot, field};
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] t);
        trig = t;
        step();
        trig = 4'd0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vco1", int'(vco1_freq), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_mixer", int'(mixer), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;
        step();

        // Basic play on slot 2 with all generator fields programmed.
        cfg_write(2'd2, 3'd0, 16'd100);
        cfg_write(2'd2, 3'd1, 16'hF123);
        cfg_write(2'd2, 3'd2, 16'h0ABC);
        cfg_write(2'd2, 3'd3, 16'hFFFF);
        cfg_write(2'd2, 3'd4, 16'h7501);
        cfg_write(2'd2, 3'd5, 16'h000A);
        cfg_write(2'd2, 3'd6, 16'd3);
        cfg_write(2'd2, 3'd7, 16'hFFFF);
        pulse(4'b0100);
        chk("basic_load_busy", int'(busy), 1);
        step();
        chk("basic_vco1_t2", int'(vco1_freq), 100);
        chk("basic_vco2", int'(vco2_freq), 12'h123);
        chk("basic_noise", int'(noise_freq), 12'hABC);
        chk("basic_lfo", int'(lfo_freq), 10'h3FF);
        chk("basic_mixer", int'(mixer), 1);
        chk("basic_shift", int'(lfo_shift), 5);
        chk("basic_sel", int'({noise_select, vco2_select, vco1_select}), 7);
        chk("basic_slot", int'(active_slot), 2);
        repeat (4) step();
        chk("basic_vco1_110", int'(vco1_freq), 110);
        repeat (4) step();
        chk("basic_vco1_120", int'(vco1_freq), 120);
        repeat (4) step();
        chk("basic_done", int'(done), 1);
        chk("basic_idle_busy", int'(busy), 0);
        chk("basic_idle_mixer", int'(mixer), 0);
        chk("basic_hold_vco1", int'(vco1_freq), 120);
        step();
        chk("basic_done_once", int'(done), 0);

        // Saturation up and down on slot 0.
        cfg_write(2'd0, 3'd0, 16'd4090);
        cfg_write(2'd0, 3'd4, 16'h0002);
        cfg_write(2'd0, 3'd5, 16'd8);
        cfg_write(2'd0, 3'd6, 16'd3);
        pulse(4'b0001);
        step();
        chk("sat_hi_start", int'(vco1_freq), 4090);
        repeat (4) step();
        chk("sat_hi_1", int'(vco1_freq), 4095);
        repeat (4) step();
        chk("sat_hi_2", int'(vco1_freq), 4095);
        wait_idle();
        cfg_write(2'd0, 3'd0, 16'd5);
        cfg_write(2'd0, 3'd5, 16'h00F8);
        cfg_write(2'd0, 3'd6, 16'd2);
        pulse(4'b0001);
        step();
        chk("sat_lo_start", int'(vco1_freq), 5);
        repeat (4) step();
        chk("sat_lo_1", int'(vco1_freq), 0);
        wait_idle();

        // Preemption of slot 3 by slot 1.
        cfg_write(2'd3, 3'd0, 16'd300);
        cfg_write(2'd3, 3'd4, 16'h0004);
        cfg_write(2'd3, 3'd6, 16'd100);
        cfg_write(2'd1, 3'd0, 16'd200);
        cfg_write(2'd1, 3'd4, 16'h0003);
        cfg_write(2'd1, 3'd5, 16'h0001);
        cfg_write(2'd1, 3'd6, 16'd2);
        pulse(4'b1000);
        repeat (5) step();
        pulse(4'b0010);
        chk("pre_load_busy", int'(busy), 1);
        chk("pre_no_done", int'(done), 0);
        step();
        chk("pre_slot", int'(active_slot), 1);
        chk("pre_vco1", int'(vco1_freq), 200);
        chk("pre_mixer", int'(mixer), 3);
        wait_idle();
        repeat (3) step();
        chk("pre_no_resume", int'(busy), 0);

        // Simultaneous triggers: slot 1 then slot 3 back to back.
        cfg_write(2'd3, 3'd6, 16'd1);
        pulse(4'b1010);
        step();
        chk("sim_first", int'(active_slot), 1);
        step();
        pulse(4'b1000);
        chk("sim_no_preempt", int'(active_slot), 1);
        repeat (6) step();
        chk("sim_done", int'(done), 1);
        chk("sim_no_gap", int'(busy), 1);
        step();
        chk("sim_second", int'(active_slot), 3);
        chk("sim_vco1", int'(vco1_freq), 300);
        wait_idle();

        // Duration 0 plays one tick with no sweep.
        cfg_write(2'd2, 3'd6, 16'd0);
        pulse(4'b0100);
        repeat (4) step();
        chk("dur0_busy", int'(busy), 1);
        step();
        chk("dur0_end", int'(busy), 0);
        chk("dur0_done", int'(done), 1);
        chk("dur0_vco1", int'(vco1_freq), 100);

        // Retrigger of the active slot replays it once.
        cfg_write(2'd2, 3'd6, 16'd1);
        pulse(4'b0100);
        step();
        pulse(4'b0100);
        chk("retrig_slot", int'(active_slot), 2);
        repeat (3) step();
        chk("retrig_done1", int'(done), 1);
        chk("retrig_replay", int'(busy), 1);
        repeat (5) step();
        chk("retrig_end", int'(busy), 0);
        chk("retrig_done2", int'(done), 1);
        step();

        // Config write to the active slot waits for the next play.
        cfg_write(2'd2, 3'd5, 16'd0);
        cfg_write(2'd2, 3'd6, 16'd3);
        pulse(4'b0100);
        step();
        chk("cfgplay_before", int'(vco1_freq), 100);
        cfg_write(2'd2, 3'd0, 16'd777);
        repeat (4) step();
        chk("cfgplay_held", int'(vco1_freq), 100);
        wait_idle();
        pulse(4'b0100);
        step();
        chk("cfgplay_next", int'(vco1_freq), 777);
        wait_idle();

        // Asynchronous reset in the middle of a play.
        cfg_write(2'd0, 3'd0, 16'd50);
        cfg_write(2'd0, 3'd4, 16'h0005);
        cfg_write(2'd0, 3'd5, 16'd1);
        cfg_write(2'd0, 3'd6, 16'd50);
        pulse(4'b0001);
        repeat (3) step();
        chk("rst_pre_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_mixer", int'(mixer), 0);
        chk("rst_async_vco1", int'(vco1_freq), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        pulse(4'b0001);
        step();
        chk("rst_replay_busy", int'(busy), 1);
        chk("rst_replay_vco1", int'(vco1_freq), 0);
        chk("rst_replay_mixer", int'(mixer), 0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
